// File: rtl/multi_stage_trigger_pkg.sv
// Shared types and constants for the multi-stage masked-pattern trigger.
// The default constants describe the 64-bit DES benchmark instance.
package multi_stage_trigger_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_SEEK     = 2'd1,
    ST_FIRED    = 2'd2
  } state_e;

  // Width of the stage index, which must also be able to hold STAGES itself.
  function automatic int stage_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  localparam int DES_DATA_W = 64;
  localparam int DES_STAGES = 4;

  localparam logic [DES_STAGES*DES_DATA_W-1:0] DES_PATTERNS = {
    64'hCAFE_F00D_5A5A_A5A5,  // stage 3
    64'h1357_9BDF_2468_ACE0,  // stage 2
    64'hDEAD_BEEF_0000_0000,  // stage 1
    64'h0123_4567_89AB_CDEF   // stage 0
  };

  localparam logic [DES_STAGES*DES_DATA_W-1:0] DES_MASKS = {
    64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_FFFF_FF00,
    64'hFFFF_FFFF_0000_0000,
    64'hFFFF_FFFF_FFFF_FFFF
  };

endpackage

// File: rtl/multi_stage_trigger_masked_match.sv
// Combinational compare of one data word against one pattern under a bit mask.
module multi_stage_trigger_masked_match #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] mask,
  output logic              hit
);

  assign hit = valid & (((data ^ pattern) & mask) == '0);

endmodule

// File: rtl/multi_stage_trigger.sv
// Ordered multi-stage trigger: each masked pattern must follow the previous
// one within a cycle window; the last match raises a sticky trigger.
module multi_stage_trigger
  import multi_stage_trigger_pkg::*;
#(
  parameter int                         DATA_W   = DES_DATA_W,
  parameter int                         STAGES   = DES_STAGES,
  parameter int                         WIN_W    = 5,
  parameter logic [STAGES*DATA_W-1:0]   PATTERNS = DES_PATTERNS,
  parameter logic [STAGES*DATA_W-1:0]   MASKS    = DES_MASKS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         data_valid,
  input  logic                         arm,
  input  logic                         clear,
  output logic                         trig,
  output logic [stage_w(STAGES)-1:0]   stage,
  output logic [7:0]                   fire_count
);

  localparam int SW = stage_w(STAGES);
  // Counter values 0 .. 2**WIN_W-2 are in-window, i.e. 2**WIN_W-1 cycles.
  localparam logic [WIN_W-1:0] LAST_CNT = WIN_W'((2 ** WIN_W) - 2);

  state_e            state_q, state_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [WIN_W-1:0]  cnt_q, cnt_d;
  logic              trig_q, trig_d;
  logic [7:0]        fire_count_q, fire_count_d;

  logic [DATA_W-1:0] cur_pattern, cur_mask;
  logic              cur_hit, restart_hit;

  always_comb begin
    cur_pattern = '0;
    cur_mask    = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_q == SW'(k)) begin
        cur_pattern = PATTERNS[k*DATA_W +: DATA_W];
        cur_mask    = MASKS[k*DATA_W +: DATA_W];
      end
    end
  end

  multi_stage_trigger_masked_match #(.DATA_W(DATA_W)) u_cur_match (
    .data    (data_in),
    .valid   (data_valid),
    .pattern (cur_pattern),
    .mask    (cur_mask),
    .hit     (cur_hit)
  );

  // A timeout re-examines the same word as a fresh stage-0 candidate.
  multi_stage_trigger_masked_match #(.DATA_W(DATA_W)) u_restart_match (
    .data    (data_in),
    .valid   (data_valid),
    .pattern (PATTERNS[0 +: DATA_W]),
    .mask    (MASKS[0 +: DATA_W]),
    .hit     (restart_hit)
  );

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    cnt_d        = cnt_q;
    fire_count_d = fire_count_q;

    if (!arm) begin
      state_d = ST_DISARMED;
      stage_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_DISARMED: begin
          state_d = ST_SEEK;
          stage_d = '0;
          cnt_d   = '0;
        end
        ST_SEEK: begin
          if (clear) begin
            stage_d = '0;
            cnt_d   = '0;
          end else if (cur_hit) begin
            cnt_d = '0;
            if (stage_q == SW'(STAGES - 1)) begin
              state_d = ST_FIRED;
              stage_d = SW'(STAGES);
              if (fire_count_q != 8'hFF) fire_count_d = fire_count_q + 8'd1;
            end else begin
              stage_d = stage_q + SW'(1);
            end
          end else if (stage_q != '0) begin
            if (cnt_q == LAST_CNT) begin
              cnt_d   = '0;
              stage_d = restart_hit ? SW'(1) : '0;
            end else begin
              cnt_d = cnt_q + WIN_W'(1);
            end
          end
        end
        ST_FIRED: begin
          if (clear) begin
            state_d = ST_SEEK;
            stage_d = '0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_DISARMED;
          stage_d = '0;
          cnt_d   = '0;
        end
      endcase
    end

    trig_d = (state_d == ST_FIRED);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_DISARMED;
      stage_q      <= '0;
      cnt_q        <= '0;
      trig_q       <= 1'b0;
      fire_count_q <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      cnt_q        <= cnt_d;
      trig_q       <= trig_d;
      fire_count_q <= fire_count_d;
    end
  end

  assign trig       = trig_q;
  assign stage      = stage_q;
  assign fire_count = fire_count_q;

endmodule
